// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the parallel-to-serial front end of the sequence
// detector.
//   ser_state_t  : state encoding of the bit_serializer FSM
//   SER_IDLE_BIT : level driven on ser_out while nothing is being sent
// -----------------------------------------------------------------------------
package serial_pkg;

   typedef enum logic [1:0] {
      SER_IDLE   = 2'd0,
      SER_SHIFT  = 2'd1,
      SER_PARITY = 2'd2
   } ser_state_t;

   localparam logic SER_IDLE_BIT = 1'b0;

endpackage : serial_pkg

// File: rtl/bit_serializer_skid_hold.sv
// -----------------------------------------------------------------------------
// skid_hold
// Single-entry holding register between the word producer and the shifter.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_data, in_valid     word offered by the producer
//   in_ready              high while the entry is empty (= !hold_vld)
//   load                  strobe from the shifter: entry consumed this cycle
//   hold_data, hold_vld   current entry and its occupancy flag
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// A transfer that coincides with load keeps the entry full with the new word.
// -----------------------------------------------------------------------------
module skid_hold #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             load,
   output logic [WIDTH-1:0] hold_data,
   output logic             hold_vld
);

   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_vld_q, hold_vld_d;
   logic             accept;

   always_comb begin
      accept     = in_valid && !hold_vld_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (load) begin
         hold_vld_d = 1'b0;
      end
      // Accept is evaluated after load so a new word wins over the drain.
      if (accept) begin
         hold_vld_d = 1'b1;
         hold_d     = in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

   assign in_ready  = !hold_vld_q;
   assign hold_data = hold_q;
   assign hold_vld  = hold_vld_q;

endmodule : skid_hold

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial stage feeding the sequence detector. Buffers one word in
// skid_hold and shifts words out one bit per clock, gap-free when streaming.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   in_data        WIDTH-bit word to serialize
//   in_valid       in_data valid
//   in_ready       holding register empty (word accepted on in_valid&&in_ready)
//   ser_out        registered serial bit, SER_IDLE_BIT when idle
//   ser_valid      ser_out carries a data or parity bit
//   busy           shifter active or holding register occupied
//   dbg_state      current FSM state (observation only)
// Parameters: WIDTH (2..32), LSB_FIRST (0: MSB first, 1: LSB first).
// Build option: define BIT_SERIALIZER_PARITY_EN to append an even parity bit
// after every word (per-word period WIDTH+1 instead of WIDTH).
// -----------------------------------------------------------------------------
module bit_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output ser_state_t       dbg_state
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic [WIDTH-1:0] hold_data;
   logic             hold_vld;
   logic             load;

   skid_hold #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .load      (load),
      .hold_data (hold_data),
      .hold_vld  (hold_vld)
   );

   // Bit that leaves first from a word in the given orientation.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   // Word with the head bit removed, next bit moved into the head position.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   // cnt_q counts bits already placed on ser_out for the current word;
   // the word is complete once cnt_q reaches WIDTH.
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      cnt_d       = cnt_q;
      ser_out_d   = SER_IDLE_BIT;
      ser_valid_d = 1'b0;
      load        = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_d    = parity_q;
`endif

      case (state_q)
         SER_IDLE: begin
            if (hold_vld) begin
               load = 1'b1;
            end
         end

         SER_SHIFT: begin
            if (cnt_q != CNT_LAST) begin
               ser_out_d   = head_bit(sh_q);
               ser_valid_d = 1'b1;
               sh_d        = advance(sh_q);
               cnt_d       = cnt_q + CNT_ONE;
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
               state_d     = SER_PARITY;
               ser_out_d   = parity_q;
               ser_valid_d = 1'b1;
`else
               if (hold_vld) begin
                  load = 1'b1;
               end else begin
                  state_d = SER_IDLE;
                  cnt_d   = '0;
               end
`endif
            end
         end

`ifdef BIT_SERIALIZER_PARITY_EN
         SER_PARITY: begin
            if (hold_vld) begin
               load = 1'b1;
            end else begin
               state_d = SER_IDLE;
               cnt_d   = '0;
            end
         end
`endif

         default: begin
            state_d = SER_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Loading puts the first bit out in the same edge, so there is no
      // bubble between the last bit of one word and the first of the next.
      if (load) begin
         state_d     = SER_SHIFT;
         ser_out_d   = head_bit(hold_data);
         ser_valid_d = 1'b1;
         sh_d        = advance(hold_data);
         cnt_d       = CNT_ONE;
`ifdef BIT_SERIALIZER_PARITY_EN
         parity_d    = ^hold_data;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SER_IDLE;
         sh_q        <= '0;
         cnt_q       <= '0;
         ser_out_q   <= SER_IDLE_BIT;
         ser_valid_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
`ifdef BIT_SERIALIZER_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign busy      = (state_q != SER_IDLE) || hold_vld;
   assign dbg_state = state_q;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
// Two 8-bit instances: dut 0 sends MSB first, dut 1 sends LSB first.
// Expected serial bits are queued when a word is accepted and popped as the
// DUT emits valid bits. Honors BIT_SERIALIZER_PARITY_EN for the period and
// the appended parity bit.
// Handshake: a word transfers on the rising edge where in_valid && in_ready.
// -----------------------------------------------------------------------------
module tb_bit_serializer;
   import serial_pkg::*;

`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int PER = 9;
`else
   localparam int PER = 8;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   logic [1:0]      in_valid = '0;
   logic [1:0][7:0] in_data  = '0;
   logic [1:0]      in_ready, ser_out, ser_valid, busy;
   ser_state_t      dbg0, dbg1;

   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .reset_n(reset_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
      .busy(busy[0]), .dbg_state(dbg0));

   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
      .busy(busy[1]), .dbg_state(dbg1));

   // ---------------- scoreboard state ----------------
   logic [0:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int acc_cyc = 0;

   // ---------------- driver ----------------
   // Offers word w to dut s, waits for acceptance, queues its expected bits.
   task automatic send(input int s, input logic [7:0] w);
      @(negedge clk);
      in_valid[s] = 1'b1;
      in_data[s]  = w;
      for (int i = 0; i < 200; i++) begin
         if (in_ready[s]) break;
         @(negedge clk);
      end
      if (!in_ready[s]) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: dut %0d word %h in_ready=%b required 1", s, w, in_ready[s]);
         in_valid[s] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         acc_cyc = cyc;
         for (int b = 0; b < 8; b++) begin
            exp_q.push_back((s == 1) ? w[b] : w[7-b]);
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         exp_q.push_back(^w);
`endif
         in_valid[s] = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset_n  = 1'b0;
      in_valid = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready[0]); end
      n_cmp++; if (ser_valid[0] !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid: got %b want 0", ser_valid[0]); end
      n_cmp++; if (ser_out[0] !== 1'b0) begin n_err++; $display("FAIL reset_ser_out: got %b want 0", ser_out[0]); end
      n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
      n_cmp++; if (dbg0 !== SER_IDLE) begin n_err++; $display("FAIL reset_state0: got %0d want %0d", dbg0, SER_IDLE); end
      n_cmp++; if (dbg1 !== SER_IDLE) begin n_err++; $display("FAIL reset_state1: got %0d want %0d", dbg1, SER_IDLE); end
      n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_lsb: got %b want 1", in_ready[1]); end
   endtask

   task automatic test_single_msb;
      int first, last, cnt;
      logic [0:0] e;
      first = -1; last = -1; cnt = 0;
      fork
         send(0, 8'hB5);
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ser_valid[0]) begin
               cnt++;
               if (first < 0) first = cyc;
               last = cyc;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++; $display("FAIL single_extra_bit: cycle %0d ser_out=%b, none expected", cyc, ser_out[0]);
               end else begin
                  e = exp_q.pop_front();
                  if (ser_out[0] !== e) begin n_err++; $display("FAIL single_bit: cycle %0d got %b want %b", cyc, ser_out[0], e); end
               end
            end else begin
               n_cmp++;
               if (ser_out[0] !== 1'b0) begin n_err++; $display("FAIL single_idle_level: cycle %0d got %b want 0", cyc, ser_out[0]); end
            end
         end
      join
      n_cmp++; if (first !== acc_cyc + 1) begin n_err++; $display("FAIL single_latency: first valid cycle %0d want %0d", first, acc_cyc + 1); end
      n_cmp++; if (cnt !== PER) begin n_err++; $display("FAIL single_valid_count: got %0d want %0d", cnt, PER); end
      n_cmp++; if (last - first + 1 !== cnt) begin n_err++; $display("FAIL single_contiguous: span %0d count %0d", last - first + 1, cnt); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL single_missing_bits: %0d left want 0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back;
      int first, last, cnt;
      bit saw_not_ready;
      logic [0:0] e;
      first = -1; last = -1; cnt = 0; saw_not_ready = 1'b0;
      fork
         begin
            send(0, 8'hF0);
            send(0, 8'h0F);
            send(0, 8'hAA);
         end
         for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!in_ready[0]) saw_not_ready = 1'b1;
            if (ser_valid[0]) begin
               cnt++;
               if (first < 0) first = cyc;
               last = cyc;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++; $display("FAIL b2b_extra_bit: cycle %0d ser_out=%b, none expected", cyc, ser_out[0]);
               end else begin
                  e = exp_q.pop_front();
                  if (ser_out[0] !== e) begin n_err++; $display("FAIL b2b_bit: cycle %0d got %b want %b", cyc, ser_out[0], e); end
               end
            end
         end
      join
      n_cmp++; if (cnt !== 3 * PER) begin n_err++; $display("FAIL b2b_valid_count: got %0d want %0d", cnt, 3 * PER); end
      n_cmp++; if (last - first + 1 !== cnt) begin n_err++; $display("FAIL b2b_contiguous: span %0d count %0d", last - first + 1, cnt); end
      n_cmp++; if (saw_not_ready !== 1'b1) begin n_err++; $display("FAIL b2b_backpressure: in_ready low seen=%b want 1", saw_not_ready); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_missing_bits: %0d left want 0", exp_q.size()); end
      n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL b2b_busy_after: got %b want 0", busy[0]); end
      exp_q.delete();
   endtask

   task automatic test_lsb_first;
      int first, last, cnt;
      logic [0:0] e;
      logic [7:0] w;
      first = -1; last = -1; cnt = 0;
      fork
         begin
            send(1, 8'h01);
            for (int k = 0; k < 3; k++) begin
               w = 8'($urandom_range(0, 255));
               send(1, w);
            end
         end
         for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (ser_valid[1]) begin
               cnt++;
               if (first < 0) first = cyc;
               last = cyc;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++; $display("FAIL lsb_extra_bit: cycle %0d ser_out=%b, none expected", cyc, ser_out[1]);
               end else begin
                  e = exp_q.pop_front();
                  if (ser_out[1] !== e) begin n_err++; $display("FAIL lsb_bit: cycle %0d got %b want %b", cyc, ser_out[1], e); end
               end
            end
         end
      join
      n_cmp++; if (cnt !== 4 * PER) begin n_err++; $display("FAIL lsb_valid_count: got %0d want %0d", cnt, 4 * PER); end
      n_cmp++; if (last - first + 1 !== cnt) begin n_err++; $display("FAIL lsb_contiguous: span %0d count %0d", last - first + 1, cnt); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL lsb_missing_bits: %0d left want 0", exp_q.size()); end
      exp_q.delete();
   endtask

`ifdef BIT_SERIALIZER_PARITY_EN
   task automatic test_parity;
      int cnt;
      logic [0:0] e;
      cnt = 0;
      fork
         begin
            send(0, 8'h07);
            send(0, 8'h03);
         end
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ser_valid[0]) begin
               cnt++;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++; $display("FAIL parity_extra_bit: cycle %0d ser_out=%b, none expected", cyc, ser_out[0]);
               end else begin
                  e = exp_q.pop_front();
                  if (ser_out[0] !== e) begin n_err++; $display("FAIL parity_bit: cycle %0d got %b want %b", cyc, ser_out[0], e); end
               end
            end
         end
      join
      n_cmp++; if (cnt !== 18) begin n_err++; $display("FAIL parity_valid_count: got %0d want 18", cnt); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL parity_missing_bits: %0d left want 0", exp_q.size()); end
      exp_q.delete();
   endtask
`endif

   task automatic test_reset_mid;
      int got, stray;
      logic [0:0] e;
      got = 0; stray = 0;
      fork
         begin
            send(0, 8'hB5);
            send(0, 8'h3C);
         end
         for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (ser_valid[0]) begin
               got++;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++; $display("FAIL mid_extra_bit: cycle %0d, none expected", cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (ser_out[0] !== e) begin n_err++; $display("FAIL mid_bit: cycle %0d got %b want %b", cyc, ser_out[0], e); end
               end
            end
         end
      join
      n_cmp++; if (got !== 4) begin n_err++; $display("FAIL mid_bits_before_reset: got %0d want 4", got); end
      n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL mid_hold_full: in_ready=%b want 0", in_ready[0]); end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (ser_valid[0] !== 1'b0) begin n_err++; $display("FAIL mid_async_ser_valid: got %b want 0", ser_valid[0]); end
      n_cmp++; if (ser_out[0] !== 1'b0) begin n_err++; $display("FAIL mid_async_ser_out: got %b want 0", ser_out[0]); end
      n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL mid_async_in_ready: got %b want 1", in_ready[0]); end
      n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL mid_async_busy: got %b want 0", busy[0]); end
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ser_valid[0] || busy[0]) stray++;
      end
      n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL mid_after_release: %0d active cycles want 0", stray); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single_msb();
      test_back_to_back();
      test_lsb_first();
`ifdef BIT_SERIALIZER_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_bit_serializer

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial stage that feeds the serial `in` input of the sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and emits them one bit per clock on `ser_out` with no gaps between back-to-back words. The output is registered, so the detector samples a clean, glitch-free bit stream.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `LSB_FIRST`, default 0: 0 = MSB transmitted first, 1 = LSB transmitted first.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `in_data`  input  WIDTH  word to serialize.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `ser_out`  output  1  serial bit to the detector; 0 when idle.
- `ser_valid`  output  1  `ser_out` carries a data or parity bit this cycle.
- `busy`  output  1  shifter active or holding register occupied.

## Operation
- **Storage.** Holding register `hold` with flag `hold_vld`; shift register `sh`; bit counter `cnt` of width $clog2(WIDTH+1).
- **`in_ready`.** Equals `!hold_vld` (combinational from the flop). A transfer occurs when `in_valid && in_ready` at a rising edge; it sets `hold_vld` and captures `in_data`.
- **Producer rule.** `in_data` is ignored when `in_valid` is low. The producer must hold `in_data` stable while `in_valid` is high and `in_ready` is low.
- **FSM states.**
  - IDLE: `ser_valid`=0 and `ser_out`=0. If `hold_vld`: load `sh` from `hold`, clear `hold_vld`, drive the first bit, go to SHIFT.
  - SHIFT: drive the next bit each cycle. After the WIDTH-th bit:
    - with parity enabled, go to PARITY;
    - otherwise, if `hold_vld`, reload immediately and stay in SHIFT;
    - else go to IDLE.
  - PARITY: drive the parity bit for one cycle. Then reload and go to SHIFT if `hold_vld`, else go to IDLE.
- **Simultaneous load and accept.** If `hold` is loaded into `sh` in the same cycle that a new word is accepted, the new word wins: `hold_vld` stays 1 and `hold` takes the new word.
- **Bit order.** `LSB_FIRST`=0 sends `in_data[WIDTH-1]` first; `LSB_FIRST`=1 sends `in_data[0]` first.
- **`busy`.** Equals `(state != IDLE) || hold_vld`.
- **Reset.** `reset_n` low mid-word aborts immediately. The partial word and the held word are discarded; no completion is signalled.

## Timing
- **Reset values.** `ser_out`=0, `ser_valid`=0, `in_ready`=1, `busy`=0, state IDLE, `hold_vld`=0, `cnt`=0.
- **Latency.** A word accepted at edge N with the shifter idle produces its first bit on `ser_out` after edge N+1. Its bits occupy cycles N+1..N+WIDTH.
- **Streaming.** Back-to-back words produce continuous `ser_valid`=1 with no idle cycle. Each word occupies WIDTH cycles, or WIDTH+1 with parity.
- **Buffering limit.** At most one word is buffered beyond the word being shifted. `in_ready` falls the cycle after a transfer into `hold` and rises the cycle after `hold` is loaded into `sh`.
- **Exit.** `ser_out` returns to 0 on the cycle after the last bit if no word is pending.

## Configuration
- Macro `BIT_SERIALIZER_PARITY_EN`.
- **Defined:** after each word one extra cycle drives the even parity bit (XOR of all WIDTH data bits) with `ser_valid`=1. Per-word period is WIDTH+1.
- **Undefined:** no PARITY state exists; per-word period is WIDTH.

## Structure
- **Shared package `serial_pkg`:** state typedef `ser_state_t` {`SER_IDLE`, `SER_SHIFT`, `SER_PARITY`} and the idle-level constant `SER_IDLE_BIT` = 1'b0.
- **Sub-module:** `skid_hold` — single-entry holding register with valid/ready and load strobe — is natural. The shifter, counter and FSM stay in `bit_serializer`.

## Test plan
- **Reset.** Hold `reset_n` low, then release → `in_ready`=1, `ser_valid`=0, `ser_out`=0, `busy`=0.
- **Single word, MSB first.** WIDTH=8, LSB_FIRST=0, one word 0xB5 → `ser_out` = 1,0,1,1,0,1,0,1 on 8 consecutive cycles starting one cycle after the transfer; `ser_valid` high for exactly those 8 cycles.
- **Back-to-back with backpressure.** Words 0xF0, 0x0F, 0xAA offered continuously → 24 contiguous `ser_valid` cycles. `in_ready` deasserts while `hold` is full, and no word is lost or duplicated.
- **LSB first.** LSB_FIRST=1, word 0x01 → `ser_out` = 1,0,0,0,0,0,0,0.
- **Parity.** With `BIT_SERIALIZER_PARITY_EN`, word 0x07 → 8 data bits then parity bit 1; word 0x03 → parity bit 0; `ser_valid` high for 9 cycles per word.
- **Reset mid-operation.** Assert `reset_n` low after bit 4 of 0xB5 while 0x3C is held → outputs reach reset values asynchronously, and nothing further is emitted after release.
- **Detector link.** Connect to the detector and stream 0b1011 (MSB first, WIDTH=4) → the detector's `out` pulses once at the expected cycle.
